// File: rtl/vend_ctrl_n_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_n_if
// Function : Front-panel / actuator bundle for vend_ctrl_n.
// Revision : 1.0
// ============================================================================
interface vend_ctrl_n_if #(
    parameter int NUM_ITEMS = 3,
    parameter int CREDIT_W  = 4
);
    logic                 coin5;
    logic                 coin10;
    logic [NUM_ITEMS-1:0] sel;
    logic                 cancel;
    logic                 restock;
    logic [NUM_ITEMS-1:0] available;
    logic [NUM_ITEMS-1:0] drop;
    logic                 change5;
    logic                 change10;
    logic                 coin_reject;
    logic [CREDIT_W-1:0]  credit;
    logic [1:0]           state;

    modport master (
        output coin5, coin10, sel, cancel, restock,
        input  available, drop, change5, change10, coin_reject, credit, state
    );

    modport slave (
        input  coin5, coin10, sel, cancel, restock,
        output available, drop, change5, change10, coin_reject, credit, state
    );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_n
// Function : N-product vending controller with priced items, stock counters,
//            saturating credit and serial change. Macro VEND_MULTI_VEND_EN
//            keeps leftover credit after a purchase instead of refunding it.
// Revision : 1.0
// ============================================================================
module vend_ctrl_n #(
    parameter int                     NUM_ITEMS  = 3,
    parameter int                     CREDIT_W   = 4,
    parameter int                     STOCK_W    = 4,
    parameter int                     INIT_STOCK = 8,
    parameter int                     MAX_CREDIT = 10,
    parameter logic [8*NUM_ITEMS-1:0] PRICE_VEC  = {8'd5, 8'd3, 8'd2}
) (
    input  logic          clk,
    input  logic          rst_n,
    vend_ctrl_n_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_DROP   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam int SUM_W = CREDIT_W + 2;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CREDIT_W-1:0]  r_credit;
    logic [CREDIT_W-1:0]  w_credit_nxt;
    logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] r_item;
    logic [NUM_ITEMS-1:0] w_item_nxt;
    logic [NUM_ITEMS-1:0] r_available;
    logic [NUM_ITEMS-1:0] w_avail_now;
    logic                 r_coin_reject;
    logic                 w_coin_reject_nxt;
    logic [CREDIT_W-1:0]  w_price [NUM_ITEMS];
    logic [CREDIT_W-1:0]  w_item_price;
    logic [1:0]           w_coin_val;
    logic [SUM_W-1:0]     w_credit_sum;
    logic                 w_coin_any;
    logic                 w_over;
    logic                 w_sel_ok;
    logic [NUM_ITEMS-1:0] w_drop;
    logic                 w_change5;
    logic                 w_change10;

    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
        localparam logic [7:0] c_PRICE8 = PRICE_VEC[8*gi +: 8];
        assign w_price[gi]     = CREDIT_W'(c_PRICE8);
        assign w_avail_now[gi] = (r_stock[gi] != '0) && (r_credit >= w_price[gi]);
    end

    always_comb begin
        w_item_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (r_item[i]) begin
                w_item_price = w_item_price | w_price[i];
            end
        end
    end

    // coin10 weighs 2, coin5 weighs 1, so the pair is already the binary value
    assign w_coin_val   = {bus.coin10, bus.coin5};
    assign w_coin_any   = |w_coin_val;
    assign w_credit_sum = SUM_W'(r_credit) + SUM_W'(w_coin_val);
    assign w_over       = w_credit_sum > SUM_W'(MAX_CREDIT);
    // Live check guards against the registered flag lagging a credit/stock change
    assign w_sel_ok     = $onehot(bus.sel) && (|(bus.sel & r_available & w_avail_now));

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_item_nxt        = r_item;
        w_coin_reject_nxt = 1'b0;
        w_drop            = '0;
        w_change5         = 1'b0;
        w_change10        = 1'b0;
        case (r_state)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel && (r_state == S_CREDIT)) begin
                    w_state_nxt       = S_CHANGE;
                    w_coin_reject_nxt = w_coin_any;
                end else if (w_sel_ok) begin
                    w_item_nxt        = bus.sel;
                    w_state_nxt       = S_DROP;
                    w_coin_reject_nxt = w_coin_any;
                end else if (w_coin_any) begin
                    if (w_over) begin
                        w_coin_reject_nxt = 1'b1;
                    end else begin
                        w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
                        w_state_nxt  = S_CREDIT;
                    end
                end
            end
            S_DROP: begin
                w_drop            = r_item;
                w_coin_reject_nxt = w_coin_any;
                w_credit_nxt      = r_credit - w_item_price;
                if (w_credit_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
`ifdef VEND_MULTI_VEND_EN
                    w_state_nxt = S_CREDIT;
`else
                    w_state_nxt = S_CHANGE;
`endif
                end
            end
            S_CHANGE: begin
                w_coin_reject_nxt = w_coin_any;
                if (r_credit >= CREDIT_W'(2)) begin
                    w_change10   = 1'b1;
                    w_credit_nxt = r_credit - CREDIT_W'(2);
                end else if (r_credit != '0) begin
                    w_change5    = 1'b1;
                    w_credit_nxt = r_credit - CREDIT_W'(1);
                end
                if (w_credit_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_item        <= '0;
            r_available   <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_item        <= w_item_nxt;
            r_available   <= w_avail_now;
            r_coin_reject <= w_coin_reject_nxt;
        end
    end

    // Restock overrides the decrement of a coincident dispense
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (!rst_n || bus.restock) begin
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end else if ((r_state == S_DROP) && r_item[i]) begin
                r_stock[i] <= r_stock[i] - STOCK_W'(1);
            end
        end
    end

    assign bus.available   = r_available;
    assign bus.drop        = w_drop;
    assign bus.change5     = w_change5;
    assign bus.change10    = w_change10;
    assign bus.coin_reject = r_coin_reject;
    assign bus.credit      = r_credit;
    assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl_n
// Function : Scoreboard bench for vend_ctrl_n with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_vend_ctrl_n;

    localparam int MAXC  = 10;
    localparam int INITS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    vend_ctrl_n_if #(.NUM_ITEMS(3), .CREDIT_W(4)) bus ();

    vend_ctrl_n dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [3:0] cr;
        logic [2:0] av;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [2:0] drop;
        logic       c5;
        logic       c10;
        logic       rej;
    } ev_t;

    typedef struct {
        int         st;
        int         cr;
        logic [2:0] av;
        logic [2:0] drop;
        bit         c5;
        bit         c10;
    } step_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];

    // Reference model: per-purchase/refund scripts of future cycles
    int    price [3] = '{2, 3, 5};
    int    m_stock [3] = '{INITS, INITS, INITS};
    step_t plan_q[$];
    step_t cur = '{0, 0, 3'b0, 3'b0, 1'b0, 1'b0};
    step_t nxt;
    int    after_cr = 0;

    task automatic plan_change(input int c);
        step_t p;
        for (int r = c; r > 0; r -= ((r >= 2) ? 2 : 1)) begin
            p.st = 3; p.cr = r; p.av = 3'b0; p.drop = 3'b0;
            p.c10 = (r >= 2); p.c5 = (r == 1);
            plan_q.push_back(p);
        end
        after_cr = 0;
    endtask

    task automatic plan_buy(input int c, input int idx);
        step_t p;
        int    rem;
        p.st = 2; p.cr = c; p.av = 3'b0; p.drop = 3'b0;
        p.drop[idx] = 1'b1; p.c5 = 1'b0; p.c10 = 1'b0;
        plan_q.push_back(p);
        rem = c - price[idx];
`ifdef VEND_MULTI_VEND_EN
        after_cr = rem;
`else
        if (rem > 0) plan_change(rem);
        else after_cr = 0;
`endif
    endtask

    task automatic model_step(input bit rstn, input bit c5i, input bit c10i,
                              input bit [2:0] s, input bit can, input bit rs);
        int    v;
        int    idx;
        bit    rej;
        bit    sel_ok;
        step_t p;
        snap_t sn;
        ev_t   e;
        v   = int'(c5i) + 2 * int'(c10i);
        rej = 1'b0;
        idx = (s == 3'b001) ? 0 : (s == 3'b010) ? 1 : 2;
        sel_ok = $onehot(s) && cur.av[idx] && (cur.cr >= price[idx]) && (m_stock[idx] != 0);
        nxt.drop = 3'b0; nxt.c5 = 1'b0; nxt.c10 = 1'b0;
        for (int i = 0; i < 3; i++) nxt.av[i] = (m_stock[i] != 0) && (cur.cr >= price[i]);
        for (int i = 0; i < 3; i++) if (cur.drop[i]) m_stock[i]--;
        if (rs || !rstn) for (int i = 0; i < 3; i++) m_stock[i] = INITS;
        if (!rstn) begin
            plan_q.delete();
            nxt.st = 0; nxt.cr = 0; nxt.av = 3'b0;
        end else if (cur.st >= 2 || (can && cur.cr > 0) || sel_ok) begin
            if (cur.st < 2) begin
                if (can && cur.cr > 0) plan_change(cur.cr);
                else plan_buy(cur.cr, idx);
            end
            rej = (v != 0);
            if (plan_q.size() > 0) begin
                p = plan_q.pop_front();
                nxt.st = p.st; nxt.cr = p.cr; nxt.drop = p.drop; nxt.c5 = p.c5; nxt.c10 = p.c10;
            end else begin
                nxt.cr = after_cr;
                nxt.st = (after_cr > 0) ? 1 : 0;
            end
        end else begin
            nxt.cr = cur.cr;
            if (v != 0) begin
                if (cur.cr + v > MAXC) rej = 1'b1;
                else nxt.cr = cur.cr + v;
            end
            nxt.st = (nxt.cr > 0) ? 1 : 0;
        end
        sn.cyc = cyc + 1; sn.st = 2'(nxt.st); sn.cr = 4'(nxt.cr); sn.av = nxt.av;
        snap_q.push_back(sn);
        if (nxt.drop != 3'b0 || nxt.c5 || nxt.c10 || rej) begin
            e.cyc = cyc + 1; e.drop = nxt.drop; e.c5 = nxt.c5; e.c10 = nxt.c10; e.rej = rej;
            ev_q.push_back(e);
        end
        cur = nxt;
    endtask

    task automatic drive(input bit rstn, input bit c5i, input bit c10i,
                         input bit [2:0] s, input bit can, input bit rs);
        @(posedge clk);
        #1;
        rst_n       = rstn;
        bus.coin5   = c5i;
        bus.coin10  = c10i;
        bus.sel     = s;
        bus.cancel  = can;
        bus.restock = rs;
        model_step(rstn, c5i, c10i, s, can, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    // Monitor: compares per-cycle status and every output pulse against the queues
    snap_t m_s;
    ev_t   m_e;
    bit    m_exp;
    bit    m_any;
    always @(negedge clk) begin
        if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            m_s = snap_q.pop_front();
            n_chk++;
            if (bus.state !== m_s.st || bus.credit !== m_s.cr || bus.available !== m_s.av)
                $display("FAIL status cyc=%0d actual st=%0d cr=%0d av=%b required st=%0d cr=%0d av=%b",
                         cyc, bus.state, bus.credit, bus.available, m_s.st, m_s.cr, m_s.av);
            else
                n_pass++;
        end
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            m_e = ev_q.pop_front();
            n_chk++;
            $display("FAIL pulse_missing cyc=%0d actual none required drop=%b c5=%b c10=%b rej=%b",
                     m_e.cyc, m_e.drop, m_e.c5, m_e.c10, m_e.rej);
        end
        m_exp = (ev_q.size() > 0) && (ev_q[0].cyc == cyc);
        m_any = (bus.drop !== 3'b000) || (bus.change5 !== 1'b0) ||
                (bus.change10 !== 1'b0) || (bus.coin_reject !== 1'b0);
        if (m_exp || m_any) begin
            if (m_exp) begin
                m_e = ev_q.pop_front();
            end else begin
                m_e.cyc = cyc; m_e.drop = 3'b0; m_e.c5 = 1'b0; m_e.c10 = 1'b0; m_e.rej = 1'b0;
            end
            n_chk++;
            if (bus.drop !== m_e.drop || bus.change5 !== m_e.c5 ||
                bus.change10 !== m_e.c10 || bus.coin_reject !== m_e.rej)
                $display("FAIL pulse cyc=%0d actual drop=%b c5=%b c10=%b rej=%b required drop=%b c5=%b c10=%b rej=%b",
                         cyc, bus.drop, bus.change5, bus.change10, bus.coin_reject,
                         m_e.drop, m_e.c5, m_e.c10, m_e.rej);
            else
                n_pass++;
        end
    end

    initial begin
        bus.coin5 = 1'b0; bus.coin10 = 1'b0; bus.sel = 3'b000;
        bus.cancel = 1'b0; bus.restock = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        idle(2);
        // water with exact credit
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0); idle(4);
        // coke with one unit of change
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0); idle(5);
        // saturate credit, overflow coin, then refund
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0); idle(8);
        // deplete water, ignored ninth purchase, restock
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); idle(1);
            drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0); idle(3);
        end
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1); idle(2);
        drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0); idle(4);
        // coin5 with cancel at credit 1
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0); idle(4);
        // credit 5 then two purchases back to back
        drive(1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0); idle(1);
        drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0); idle(2);
        drive(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0); idle(6);
        // randomized traffic including mid-operation reset
        for (int i = 0; i < 4000; i++) begin
            bit       r_c5, r_c10, r_can, r_rs, r_rn;
            bit [2:0] r_sel;
            int       p;
            r_c5  = ($urandom_range(0, 99) < 15);
            r_c10 = ($urandom_range(0, 99) < 20);
            p     = int'($urandom_range(0, 99));
            r_sel = (p < 20) ? 3'(1 << $urandom_range(0, 2)) :
                    (p < 23) ? 3'($urandom_range(0, 7)) : 3'b000;
            r_can = ($urandom_range(0, 99) < 5);
            r_rs  = ($urandom_range(0, 99) < 3);
            r_rn  = ($urandom_range(0, 199) != 0);
            drive(r_rn, r_c5, r_c10, r_sel, r_can, r_rs);
        end
        idle(40);
        @(negedge clk);
        #1;
        n_chk++;
        if (ev_q.size() != 0)
            $display("FAIL drain actual %0d pending pulses required 0", ev_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_ctrl_n.md
# vend_ctrl_n

Parametrised vending-machine controller for N products with per-product price, per-product stock counters, saturating credit and serial change dispensing. It is the next generation of the fixed three-product water/coke/coffee controller. It sits between the coin/button front panel, which delivers synchronous single-cycle pulses, and the dispenser/change-hopper actuators, which consume single-cycle pulses.

## Interface
- NUM_ITEMS, 3: number of products, range 1..8.
- CREDIT_W, 4: credit register width, in units of 5.
- STOCK_W, 4: per-product stock counter width.
- INIT_STOCK, 8: stock loaded into every product at reset and on restock; must be < 2^STOCK_W.
- MAX_CREDIT, 10: credit ceiling in units of 5; must be ≤ 2^CREDIT_W−1.
- PRICE_VEC, {8'd5,8'd3,8'd2}: packed 8-bit prices in units of 5, item 0 in bits [7:0]. Each price must be in 1..MAX_CREDIT.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- coin5 / coin10  in  1  one-cycle coin-inserted pulses.
- sel  in  NUM_ITEMS  one-cycle selection pulse, one-hot.
- cancel  in  1  one-cycle refund request.
- restock  in  1  one-cycle pulse; reloads all stock to INIT_STOCK.
- available  out  NUM_ITEMS  registered; bit i = stock[i]≠0 and credit ≥ price[i].
- drop  out  NUM_ITEMS  one-cycle dispense pulse, at most one bit set.
- change5 / change10  out  1  one-cycle change-coin pulses; never both high.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- credit  out  CREDIT_W  current credit, in units of 5.
- state  out  2  FSM state encoding.

## Operation
- States:
  - IDLE=0: credit is 0.
  - CREDIT=1: credit > 0.
  - DROP=2: one cycle; dispenses the latched item.
  - CHANGE=3: returns the remaining credit.
- Coins:
  - Accepted only in IDLE/CREDIT.
  - Value = coin5·1 + coin10·2; both high in one cycle gives value 3.
  - If credit+value > MAX_CREDIT, the whole cycle's value is refused: credit is unchanged and coin_reject pulses.
  - Coins in DROP/CHANGE are refused the same way.
  - An accepted coin moves IDLE→CREDIT.
- Priority in IDLE/CREDIT, per cycle:
  1. cancel
  2. sel
  3. coins
  - Any coin arriving in a cycle where cancel or a valid sel is acted on is refused.
- cancel:
  - In CREDIT: go to CHANGE.
  - In IDLE or the other states: ignored.
- sel:
  - Ignored if not one-hot or if available[i] is 0.
  - Otherwise latch i, then go to DROP.
- DROP, in that same cycle:
  - drop[i]=1.
  - stock[i] decrements.
  - credit decrements by price[i].
  - Next state: CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - Each cycle: if credit ≥ 2, change10=1 and credit −2; else change5=1 and credit −1.
  - Go to IDLE in the cycle credit reaches 0.
- restock:
  - Honoured in every state, including DROP.
  - Reload wins over a same-cycle DROP decrement.
- Stock never underflows, because DROP requires stock ≠ 0.

## Timing
- Reset values, on the first rising edge with rst_n=0:
  - state=IDLE, credit=0, stock[*]=INIT_STOCK.
  - drop=0, change5=0, change10=0, coin_reject=0.
  - available=0.
- Reset asserted mid-operation aborts DROP/CHANGE immediately; no further pulses are issued and the remaining credit is discarded.
- credit updates on the edge after the coin is sampled.
- available follows one cycle after credit or stock changes.
- coin_reject is asserted on the edge after the refused coin.
- drop is asserted the cycle after the accepted sel, i.e. 1-cycle latency.
- The first change pulse comes the cycle after DROP, or the cycle after cancel.
- Change for credit c takes ⌈c/2⌉ cycles.
- Inputs are sampled every cycle. The front panel must not hold pulses longer than one cycle; a held level counts as a new event each cycle.

## Configuration
- Macro: VEND_MULTI_VEND_EN.
- Defined: after DROP with remaining credit > 0, the FSM returns to CREDIT instead of CHANGE. The customer may buy again; change is returned only on cancel.
- Not defined: after DROP the FSM always goes to CHANGE when credit > 0, giving one purchase per transaction.

## Test plan
- Reset, coin10 pulse, then sel[0] (water, price 2):
  - credit=2.
  - available=3'b001.
  - drop[0] one cycle after sel.
  - credit returns to 0 and the FSM is back in IDLE.
  - No change pulses.
- coin10, coin10, then sel[1] (coke, price 3):
  - drop[1].
  - Exactly one change5 pulse.
  - stock[1] goes from 8 to 7.
- Five coin10 pulses (credit 10), then a sixth coin10:
  - coin_reject pulses.
  - credit stays 10.
  - cancel then gives five change10 pulses.
- Buy water 8 times:
  - available[0]=0 after the 8th drop.
  - A 9th sel[0] is ignored.
  - restock pulse restores available[0] one cycle later.
- coin5 in the same cycle as cancel, with credit 1:
  - coin_reject pulses.
  - Exactly one change5 pulse.
  - End state IDLE.
- VEND_MULTI_VEND_EN defined, credit 5, sel[0]:
  - FSM returns to CREDIT with credit=3.
  - sel[1] then gives drop[1] and credit=0, back to IDLE.
